// File: rtl/dmem_io_arbiter.sv
// rtl/dmem_io_arbiter.sv - shares the data RAM / board IO port between the CPU and the UART loader
// Optional round-robin arbitration with DMEM_ARB_RR_EN; fixed loader-over-CPU priority otherwise.
module dmem_io_arbiter #(
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00,
  parameter logic [9:0]  LED_OFF = 10'h060,
  parameter logic [9:0]  SW_OFF  = 10'h070,
  parameter int          MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ack,
  output logic [31:0] ld_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic        own_ld;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        err_q;
  logic [1:0]  wait_cnt;
  logic        grant_ld;
  logic        is_io;
  logic [9:0]  io_off;
  logic        io_hit;
  logic        cap_en;
  logic [31:0] cap_val;

  assign is_io  = (lat_addr[31:10] == IO_BASE[31:10]);
  assign io_off = lat_addr[9:0];
  assign io_hit = (io_off == LED_OFF) || (io_off == SW_OFF);

`ifdef DMEM_ARB_RR_EN
  // prio_ld=1 means the loader wins a tie; it points away from whoever just completed.
  logic prio_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ld <= 1'b0;
    end else if (state == S_DONE) begin
      prio_ld <= ~own_ld;
    end
  end

  assign grant_ld = ld_req && (!cpu_req || prio_ld);
`else
  assign grant_ld = ld_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    ld_ack    = 1'b0;
    bus_err   = 1'b0;
    cap_en    = 1'b0;
    cap_val   = 32'h0;
    case (state)
      S_IDLE: begin
        if (cpu_req || ld_req) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en    = !is_io;
        mem_we    = !is_io && lat_we;
        state_nxt = (!is_io && !lat_we) ? S_WAIT : S_DONE;
        // Unmapped IO reads return zero; LED reads back its current value.
        if (is_io && !lat_we) begin
          cap_en = 1'b1;
          if (io_off == SW_OFF) cap_val = {16'h0, sw_in};
          else if (io_off == LED_OFF) cap_val = {16'h0, led_out};
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          cap_en    = 1'b1;
          cap_val   = mem_rdata;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        cpu_ack   = !own_ld;
        ld_ack    = own_ld;
        bus_err   = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_ld    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      err_q     <= 1'b0;
      wait_cnt  <= 2'd0;
      led_out   <= 16'h0;
      cpu_rdata <= 32'h0;
      ld_rdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || ld_req) begin
            own_ld    <= grant_ld;
            lat_we    <= grant_ld ? ld_we    : cpu_we;
            lat_addr  <= grant_ld ? ld_addr  : cpu_addr;
            lat_wdata <= grant_ld ? ld_wdata : cpu_wdata;
          end
        end
        S_ISSUE: begin
          wait_cnt <= 2'd0;
          err_q    <= is_io && !io_hit;
          if (is_io && lat_we && (io_off == LED_OFF)) led_out <= lat_wdata[15:0];
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        default: ;
      endcase
      // Only the owner's read-data register ever changes.
      if (cap_en) begin
        if (own_ld) ld_rdata <= cap_val;
        else        cpu_rdata <= cap_val;
      end
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// tb/tb_dmem_io_arbiter.sv - scoreboard bench for dmem_io_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_dmem_io_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerr = 0;

  logic        cpu_req, cpu_we, cpu_ack, ld_req, ld_we, ld_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ld_addr, ld_wdata, ld_rdata;
  logic        mem_en, mem_we, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] sw_in, led_out;

  logic        b_ld_req, b_ld_we, b_ld_ack, b_cpu_ack, b_mem_en, b_mem_we, b_bus_err;
  logic [31:0] b_ld_addr, b_ld_wdata, b_ld_rdata, b_cpu_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_led_out;

  dmem_io_arbiter #(.MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err)
  );

  dmem_io_arbiter #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata),
    .ld_ack(b_ld_ack), .ld_rdata(b_ld_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .sw_in(16'h0), .led_out(b_led_out), .bus_err(b_bus_err)
  );

  // RAM models: one-cycle read for dut, three-stage read pipeline for dut_b.
  logic [31:0] ram_a [0:255];
  logic [31:0] ram_b [0:255];
  logic [31:0] pb1, pb2, pb3;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram_a[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram_a[mem_addr[9:2]];
    end
  end

  always @(posedge clk) begin
    if (b_mem_en) begin
      if (b_mem_we) ram_b[b_mem_addr[9:2]] <= b_mem_wdata;
      else          pb1 <= ram_b[b_mem_addr[9:2]];
    end
    pb2 <= pb1;
    pb3 <= pb2;
  end
  assign b_mem_rdata = pb3;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t cpu_q[$];
  exp_t ld_q[$];
  exp_t ldb_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name);
    nchecks++;
    nerr++;
    $display("FAIL %s: got ack/timeout expected none", name);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (cpu_ack) begin
      if (cpu_q.size() == 0) flag("cpu_ack_unexpected");
      else begin
        e = cpu_q.pop_front();
        check("cpu_ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_rd) check("cpu_rdata", cpu_rdata, e.rdata);
        check("cpu_bus_err", 32'(bus_err), 32'(e.err));
      end
    end
    if (ld_ack) begin
      if (ld_q.size() == 0) flag("ld_ack_unexpected");
      else begin
        e = ld_q.pop_front();
        check("ld_ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_rd) check("ld_rdata", ld_rdata, e.rdata);
        check("ld_bus_err", 32'(bus_err), 32'(e.err));
      end
    end
    if (b_ld_ack) begin
      if (ldb_q.size() == 0) flag("b_ld_ack_unexpected");
      else begin
        e = ldb_q.pop_front();
        check("b_ld_ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_rd) check("b_ld_rdata", b_ld_rdata, e.rdata);
        check("b_bus_err", 32'(b_bus_err), 32'(e.err));
      end
    end
  end

  task automatic cpu_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    bit   got = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    e.rdata = rdata; e.chk_rd = !we; e.err = err; e.cyc = cyc + lat;
    cpu_q.push_back(e);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = cpu_ack;
    end
    cpu_req = 1'b0;
    if (!got) flag("cpu_timeout");
  endtask

  task automatic ld_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    bit   got = 0;
    @(negedge clk);
    ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
    e.rdata = rdata; e.chk_rd = !we; e.err = err; e.cyc = cyc + lat;
    ld_q.push_back(e);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ld_ack;
    end
    ld_req = 1'b0;
    if (!got) flag("ld_timeout");
  endtask

  task automatic ldb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int lat);
    exp_t e;
    bit   got = 0;
    @(negedge clk);
    b_ld_req = 1'b1; b_ld_we = we; b_ld_addr = addr; b_ld_wdata = wdata;
    e.rdata = rdata; e.chk_rd = !we; e.err = 1'b0; e.cyc = cyc + lat;
    ldb_q.push_back(e);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = b_ld_ack;
    end
    b_ld_req = 1'b0;
    if (!got) flag("b_ld_timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    b_ld_req = 0; b_ld_we = 0; b_ld_addr = 0; b_ld_wdata = 0;
    sw_in = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    check("rst_ld_ack", 32'(ld_ack), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_led_out", 32'(led_out), 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_ld_rdata", ld_rdata, 32'h0);
    rst_n = 1'b1;

    fork
      cpu_xfer(1'b1, 32'h10, 32'h1234, 32'h0, 1'b0, 2);
      begin
        @(negedge clk);
        @(negedge clk);
        check("issue_mem_en", 32'(mem_en), 32'h1);
        check("issue_mem_we", 32'(mem_we), 32'h1);
        check("issue_mem_addr", mem_addr, 32'h10);
        @(negedge clk);
        check("done_mem_we", 32'(mem_we), 32'h0);
      end
    join
    cpu_xfer(1'b0, 32'h10, 32'h0, 32'h1234, 1'b0, 3);

    cpu_xfer(1'b1, 32'hFFFFFC60, 32'hABCD5A5A, 32'h0, 1'b0, 2);
    check("led_after_write", 32'(led_out), 32'h5A5A);
    sw_in = 16'h00F3;
    cpu_xfer(1'b0, 32'hFFFFFC70, 32'h0, 32'h000000F3, 1'b0, 2);
    cpu_xfer(1'b0, 32'hFFFFFC84, 32'h0, 32'h0, 1'b1, 2);
    cpu_xfer(1'b1, 32'hFFFFFC84, 32'h11112222, 32'h0, 1'b1, 2);
    check("led_after_unmapped_write", 32'(led_out), 32'h5A5A);

    fork
      cpu_xfer(1'b1, 32'h20, 32'h0000C0C0, 32'h0, 1'b0, 5);
      ld_xfer(1'b1, 32'h24, 32'h00001D1D, 32'h0, 1'b0, 2);
    join
    ld_xfer(1'b0, 32'h20, 32'h0, 32'h0000C0C0, 1'b0, 3);
    cpu_xfer(1'b0, 32'h24, 32'h0, 32'h00001D1D, 1'b0, 3);
    check("ld_rdata_kept", ld_rdata, 32'h0000C0C0);

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("abort_mem_en", 32'(mem_en), 32'h0);
    check("abort_cpu_ack", 32'(cpu_ack), 32'h0);
    check("abort_led_out", 32'(led_out), 32'h0);
    check("abort_cpu_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    check("abort_cpu_ack_later", 32'(cpu_ack), 32'h0);
    rst_n = 1'b1;
    cpu_xfer(1'b0, 32'h10, 32'h0, 32'h1234, 1'b0, 3);

    ldb_xfer(1'b1, 32'h40, 32'h5EED0003, 32'h0, 2);
    ldb_xfer(1'b0, 32'h40, 32'h0, 32'h5EED0003, 5);

    repeat (4) @(negedge clk);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    check("ld_q_drained", 32'(ld_q.size()), 32'h0);
    check("ldb_q_drained", 32'(ldb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
